// File: rtl/lvtram_arb_pkg.sv
// Shared types and width helpers for the LVT RAM write arbiter.
package lvtram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A DEPTH of 1 still needs a one-bit address bus.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvtram_arb_select.sv
// Combinational round-robin scan that packs up to N_WRITE conflict-free
// requesters onto the RAM write ports, starting the scan at rr.
module lvtram_arb_select
  import lvtram_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_WRITE = 2,
  parameter int AW      = 5,
  parameter int IW      = 2
) (
  input  logic [N_REQ-1:0]             valid,
  input  logic [N_REQ-1:0][AW-1:0]     addr,
  input  logic [IW-1:0]                rr,
  output logic [N_REQ-1:0]             grant,
  output logic [N_WRITE-1:0][IW-1:0]   port_src,
  output logic [N_WRITE-1:0]           port_vld,
  output logic [IW-1:0]                last_idx
);

  always_comb begin
    int k;
    int n;
    logic hit;
    logic [IW-1:0] kk;
    grant    = '0;
    port_src = '0;
    port_vld = '0;
    last_idx = rr;
    n        = 0;
    k        = 0;
    kk       = '0;
    hit      = 1'b0;
    for (int s = 0; s < N_REQ; s++) begin
      k = int'(rr) + s;
      if (k >= N_REQ) k = k - N_REQ;
      kk  = IW'(k);
      hit = 1'b0;
      // An address already claimed this cycle would make the LVT ambiguous.
      for (int j = 0; j < N_WRITE; j++) begin
        if (port_vld[j] && (addr[port_src[j]] == addr[kk])) hit = 1'b1;
      end
      if (valid[kk] && (n < N_WRITE) && !hit) begin
        grant[kk] = 1'b1;
        for (int j = 0; j < N_WRITE; j++) begin
          if (j == n) begin
            port_src[j] = kk;
            port_vld[j] = 1'b1;
          end
        end
        last_idx = kk;
        n = n + 1;
      end
    end
  end

endmodule

// File: rtl/lvtram_write_arbiter.sv
// Zero-sweeps the LVT RAM after reset or clear_req, then round-robin shares
// its write ports. Define LVTRAM_ARB_OUTREG_EN to register wen/waddr/wdata.
module lvtram_write_arbiter
  import lvtram_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int N_REQ   = 4,
  parameter int N_WRITE = 2,
  localparam int ADDR_WIDTH = addr_width(DEPTH),
  localparam int IDX_WIDTH  = idx_width(N_REQ)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0]         req_data,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic                                clear_req,
  output logic                                init_done,
  output logic [N_WRITE-1:0]                  wen,
  output logic [N_WRITE-1:0][ADDR_WIDTH-1:0]  waddr,
  output logic [N_WRITE-1:0][WIDTH-1:0]       wdata,
  output state_e                              state_dbg
);

  // Handshake: a write transfers when req_valid[i] & req_ready[i]; ready may
  // depend on valid/addr combinationally, and requesters hold valid/addr/data
  // until granted without looking at ready.

  localparam int PW = $clog2(DEPTH + N_WRITE + 1);

  state_e                             state, state_nxt;
  logic [PW-1:0]                      ptr, ptr_nxt;
  logic [IDX_WIDTH-1:0]               rr, rr_nxt;
  logic [N_REQ-1:0]                   grant;
  logic [N_WRITE-1:0][IDX_WIDTH-1:0]  port_src;
  logic [N_WRITE-1:0]                 port_vld;
  logic [IDX_WIDTH-1:0]               last_idx;
  logic [N_WRITE-1:0]                 wen_c;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr_c;
  logic [N_WRITE-1:0][WIDTH-1:0]      wdata_c;

  lvtram_arb_select #(
    .N_REQ   (N_REQ),
    .N_WRITE (N_WRITE),
    .AW      (ADDR_WIDTH),
    .IW      (IDX_WIDTH)
  ) u_select (
    .valid    (req_valid),
    .addr     (req_addr),
    .rr       (rr),
    .grant    (grant),
    .port_src (port_src),
    .port_vld (port_vld),
    .last_idx (last_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      ptr   <= '0;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rr_nxt    = rr;
    req_ready = '0;
    wen_c     = '0;
    waddr_c   = '0;
    wdata_c   = '0;
    case (state)
      INIT: begin
        // Ports beyond the last word are masked on a short final sweep.
        for (int j = 0; j < N_WRITE; j++) begin
          wen_c[j]   = (int'(ptr) + j) < DEPTH;
          waddr_c[j] = ADDR_WIDTH'(int'(ptr) + j);
        end
        ptr_nxt = ptr + PW'(N_WRITE);
        if ((int'(ptr) + N_WRITE) >= DEPTH) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end
      end
      RUN: begin
        req_ready = grant;
        for (int j = 0; j < N_WRITE; j++) begin
          if (port_vld[j]) begin
            wen_c[j]   = 1'b1;
            waddr_c[j] = req_addr[port_src[j]];
            wdata_c[j] = req_data[port_src[j]];
          end
        end
        if (|grant) begin
          rr_nxt = (last_idx == IDX_WIDTH'(N_REQ - 1)) ? '0 : last_idx + IDX_WIDTH'(1);
        end
        if (clear_req) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign state_dbg = state;

`ifdef LVTRAM_ARB_OUTREG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wen       <= '0;
      waddr     <= '0;
      wdata     <= '0;
      init_done <= 1'b0;
    end else begin
      wen       <= wen_c;
      waddr     <= waddr_c;
      wdata     <= wdata_c;
      init_done <= (state == RUN);
    end
  end
`else
  // INIT at ptr=0 would otherwise drive the sweep while reset is held.
  always_comb begin
    wen   = resetn ? wen_c   : '0;
    waddr = resetn ? waddr_c : '0;
    wdata = resetn ? wdata_c : '0;
  end
  assign init_done = (state == RUN);
`endif

endmodule

// File: tb/tb_lvtram_write_arbiter.sv
// Directed bench: default arbiter plus DEPTH=5 and N_WRITE=1 variants.
module tb_lvtram_write_arbiter;
  import lvtram_arb_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Default instance: WIDTH=32, DEPTH=32, N_REQ=4, N_WRITE=2
  logic [3:0]        dut_valid;
  logic [3:0][4:0]   dut_addr;
  logic [3:0][31:0]  dut_data;
  logic [3:0]        dut_ready;
  logic              dut_clear;
  logic              dut_done;
  logic [1:0]        dut_wen;
  logic [1:0][4:0]   dut_waddr;
  logic [1:0][31:0]  dut_wdata;
  state_e            dut_state;

  // DEPTH=5, N_WRITE=2 variant
  logic [3:0]        d5_valid;
  logic [3:0][2:0]   d5_addr;
  logic [3:0][7:0]   d5_data;
  logic [3:0]        d5_ready;
  logic              d5_clear;
  logic              d5_done;
  logic [1:0]        d5_wen;
  logic [1:0][2:0]   d5_waddr;
  logic [1:0][7:0]   d5_wdata;
  state_e            d5_state;

  // DEPTH=4, N_WRITE=1 variant
  logic [3:0]        w1_valid;
  logic [3:0][1:0]   w1_addr;
  logic [3:0][7:0]   w1_data;
  logic [3:0]        w1_ready;
  logic              w1_clear;
  logic              w1_done;
  logic [0:0]        w1_wen;
  logic [0:0][1:0]   w1_waddr;
  logic [0:0][7:0]   w1_wdata;
  state_e            w1_state;

  logic [31:0] ram [32];

  always #5 clk = ~clk;

  lvtram_write_arbiter #(.WIDTH(32), .DEPTH(32), .N_REQ(4), .N_WRITE(2)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(dut_valid), .req_addr(dut_addr),
    .req_data(dut_data), .req_ready(dut_ready), .clear_req(dut_clear),
    .init_done(dut_done), .wen(dut_wen), .waddr(dut_waddr), .wdata(dut_wdata),
    .state_dbg(dut_state)
  );

  lvtram_write_arbiter #(.WIDTH(8), .DEPTH(5), .N_REQ(4), .N_WRITE(2)) u_d5 (
    .clk(clk), .resetn(resetn), .req_valid(d5_valid), .req_addr(d5_addr),
    .req_data(d5_data), .req_ready(d5_ready), .clear_req(d5_clear),
    .init_done(d5_done), .wen(d5_wen), .waddr(d5_waddr), .wdata(d5_wdata),
    .state_dbg(d5_state)
  );

  lvtram_write_arbiter #(.WIDTH(8), .DEPTH(4), .N_REQ(4), .N_WRITE(1)) u_w1 (
    .clk(clk), .resetn(resetn), .req_valid(w1_valid), .req_addr(w1_addr),
    .req_data(w1_data), .req_ready(w1_ready), .clear_req(w1_clear),
    .init_done(w1_done), .wen(w1_wen), .waddr(w1_waddr), .wdata(w1_wdata),
    .state_dbg(w1_state)
  );

  // RAM model fed by the default instance's write ports.
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (dut_wen[j]) ram[dut_waddr[j]] <= dut_wdata[j];
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    dut_valid = '0; dut_addr = '0; dut_data = '0; dut_clear = 1'b0;
    d5_valid = '0; d5_addr = '0; d5_data = '0; d5_clear = 1'b0;
    w1_valid = '0; w1_addr = '0; w1_data = '0; w1_clear = 1'b0;
    @(negedge clk);
    dut_valid = 4'hF;
    dut_addr  = {5'd13, 5'd12, 5'd11, 5'd10};
    #1;
    checks++;
    if ({dut_wen, dut_waddr, dut_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_ports got wen=%b waddr=%h wdata=%h exp all zero", dut_wen, dut_waddr, dut_wdata);
    end
    checks++;
    if ({dut_ready, dut_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b done=%b exp 0000/0", dut_ready, dut_done);
    end
    checks++;
    if (dut_state !== INIT || d5_wen !== 2'b00 || w1_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got state=%0d d5_wen=%b w1_wen=%b exp INIT/00/0", dut_state, d5_wen, w1_wen);
    end
  endtask

  task automatic test_sweep();
    logic [9:0] exp_addr;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      dut_clear = (c == 5);
      #1;
      exp_addr = {5'(2 * c + 1), 5'(2 * c)};
      checks++;
      if (dut_wen !== 2'b11 || dut_waddr !== exp_addr || dut_wdata !== '0 ||
          dut_ready !== 4'b0000 || dut_done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_c%0d got wen=%b waddr=%h wdata=%h ready=%b done=%b exp 11/%h/0/0000/0",
                 c, dut_wen, dut_waddr, dut_wdata, dut_ready, dut_done, exp_addr);
      end
      if (c < 2) begin
        checks++;
        if (d5_wen !== 2'b11 || d5_waddr !== {3'(2 * c + 1), 3'(2 * c)} || d5_done !== 1'b0) begin
          errors++;
          $display("FAIL d5_sweep_c%0d got wen=%b waddr=%h done=%b", c, d5_wen, d5_waddr, d5_done);
        end
      end else if (c == 2) begin
        checks++;
        if (d5_wen !== 2'b01 || d5_waddr[0] !== 3'd4 || d5_done !== 1'b0) begin
          errors++;
          $display("FAIL d5_last got wen=%b waddr0=%0d done=%b exp 01/4/0", d5_wen, d5_waddr[0], d5_done);
        end
      end else begin
        checks++;
        if (d5_done !== 1'b1 || d5_wen !== 2'b00) begin
          errors++;
          $display("FAIL d5_run_c%0d got done=%b wen=%b exp 1/00", c, d5_done, d5_wen);
        end
      end
      if (c < 4) begin
        checks++;
        if (w1_wen !== 1'b1 || w1_waddr[0] !== 2'(c) || w1_done !== 1'b0) begin
          errors++;
          $display("FAIL w1_sweep_c%0d got wen=%b waddr=%0d done=%b", c, w1_wen, w1_waddr[0], w1_done);
        end
      end
    end
    @(negedge clk);
    dut_clear = 1'b0;
    dut_valid = '0;
    #1;
    checks++;
    if (dut_done !== 1'b1 || dut_state !== RUN || dut_wen !== 2'b00) begin
      errors++;
      $display("FAIL sweep_end got done=%b state=%0d wen=%b exp 1/RUN/00", dut_done, dut_state, dut_wen);
    end
    checks++;
    if (w1_done !== 1'b1) begin
      errors++;
      $display("FAIL w1_done got %b exp 1", w1_done);
    end
  endtask

  task automatic test_full_parallel();
    @(negedge clk);
    dut_valid = 4'hF;
    dut_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    dut_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    #1;
    checks++;
    if (dut_ready !== 4'b0011 || dut_wen !== 2'b11 || dut_waddr !== {5'd2, 5'd1} ||
        dut_wdata !== {32'hD1, 32'hD0}) begin
      errors++;
      $display("FAIL par_first got ready=%b wen=%b waddr=%h wdata=%h exp 0011/11/(2,1)/(D1,D0)",
               dut_ready, dut_wen, dut_waddr, dut_wdata);
    end
    @(negedge clk);
    dut_valid = 4'b1100;
    #1;
    checks++;
    if (dut_ready !== 4'b1100 || dut_wen !== 2'b11 || dut_waddr !== {5'd4, 5'd3} ||
        dut_wdata !== {32'hD3, 32'hD2}) begin
      errors++;
      $display("FAIL par_second got ready=%b wen=%b waddr=%h wdata=%h exp 1100/11/(4,3)/(D3,D2)",
               dut_ready, dut_wen, dut_waddr, dut_wdata);
    end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    dut_valid   = 4'b0011;
    dut_addr[0] = 5'd7;
    dut_addr[1] = 5'd7;
    dut_data[0] = 32'hA;
    dut_data[1] = 32'hB;
    #1;
    checks++;
    if (dut_ready !== 4'b0001 || dut_wen !== 2'b01 || dut_waddr[0] !== 5'd7 || dut_wdata[0] !== 32'hA) begin
      errors++;
      $display("FAIL conf_first got ready=%b wen=%b waddr0=%0d wdata0=%h exp 0001/01/7/A",
               dut_ready, dut_wen, dut_waddr[0], dut_wdata[0]);
    end
    // rr now points at req1, so the stalled loser takes port 0 ahead of req0.
    @(negedge clk);
    dut_addr[0] = 5'd9;
    dut_data[0] = 32'hC;
    #1;
    checks++;
    if (dut_ready !== 4'b0011 || dut_wen !== 2'b11 || dut_waddr !== {5'd9, 5'd7} ||
        dut_wdata !== {32'hC, 32'hB}) begin
      errors++;
      $display("FAIL conf_second got ready=%b wen=%b waddr=%h wdata=%h exp 0011/11/(9,7)/(C,B)",
               dut_ready, dut_wen, dut_waddr, dut_wdata);
    end
    @(negedge clk);
    dut_valid = '0;
    #1;
    checks++;
    if (ram[7] !== 32'hB || ram[9] !== 32'hC) begin
      errors++;
      $display("FAIL conf_ram got ram7=%h ram9=%h exp B/C", ram[7], ram[9]);
    end
  endtask

  task automatic test_fairness();
    int e;
    @(negedge clk);
    w1_valid = 4'hF;
    w1_addr  = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      e = c % 4;
      checks++;
      if (w1_ready !== (4'b0001 << e) || w1_wen !== 1'b1 || w1_waddr[0] !== 2'(e)) begin
        errors++;
        $display("FAIL fair_c%0d got ready=%b wen=%b waddr=%0d exp req %0d", c, w1_ready, w1_wen, w1_waddr[0], e);
      end
    end
    @(negedge clk);
    w1_valid = '0;
  endtask

  task automatic test_clear();
    @(negedge clk);
    dut_valid   = 4'b0100;
    dut_addr[2] = 5'd5;
    dut_data[2] = 32'hE;
    dut_clear   = 1'b1;
    #1;
    checks++;
    if (dut_ready !== 4'b0100 || dut_wen !== 2'b01 || dut_waddr[0] !== 5'd5 ||
        dut_wdata[0] !== 32'hE || dut_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_grant got ready=%b wen=%b waddr0=%0d wdata0=%h done=%b exp 0100/01/5/E/1",
               dut_ready, dut_wen, dut_waddr[0], dut_wdata[0], dut_done);
    end
    @(negedge clk);
    dut_clear = 1'b0;
    dut_valid = '0;
    #1;
    checks++;
    if (dut_done !== 1'b0 || dut_state !== INIT || dut_wen !== 2'b11 ||
        dut_waddr !== {5'd1, 5'd0} || dut_ready !== 4'b0000) begin
      errors++;
      $display("FAIL clear_restart got done=%b state=%0d wen=%b waddr=%h ready=%b exp 0/INIT/11/(1,0)/0000",
               dut_done, dut_state, dut_wen, dut_waddr, dut_ready);
    end
  endtask

  task automatic test_async_reset();
    int nonzero;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (dut_wen !== 2'b11 || dut_waddr !== {5'd11, 5'd10}) begin
      errors++;
      $display("FAIL arst_pre got wen=%b waddr=%h exp 11/(11,10)", dut_wen, dut_waddr);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (dut_wen !== 2'b00 || dut_waddr !== '0 || dut_done !== 1'b0 || dut_state !== INIT) begin
      errors++;
      $display("FAIL arst_drop got wen=%b waddr=%h done=%b state=%0d exp 00/0/0/INIT",
               dut_wen, dut_waddr, dut_done, dut_state);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (dut_wen !== 2'b11 || dut_waddr !== {5'd1, 5'd0}) begin
      errors++;
      $display("FAIL arst_restart got wen=%b waddr=%h exp 11/(1,0)", dut_wen, dut_waddr);
    end
    repeat (16) @(negedge clk);
    #1;
    checks++;
    if (dut_done !== 1'b1) begin
      errors++;
      $display("FAIL arst_done got %b exp 1", dut_done);
    end
    nonzero = 0;
    for (int a = 0; a < 32; a++) begin
      if (ram[a] !== 32'h0) nonzero++;
    end
    checks++;
    if (nonzero != 0) begin
      errors++;
      $display("FAIL ram_zeroed got %0d nonzero words exp 0", nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_full_parallel();
    test_conflict();
    test_fairness();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvtram_write_arbiter.md
Name: lvtram_write_arbiter

Overview:
Sequences and shares the write ports of the LVT multi-port RAM.
- Initialisation: after reset, or on request, sweeps every RAM word to zero, because the RAM contents have no reset.
- Normal operation: arbitrates N_REQ write requesters onto N_WRITE RAM write ports, round-robin.
- Never grants two same-cycle writes to the same address, so the live-value table is never ambiguous.
- Sits between producer units (e.g. writeback lanes) and the RAM's wen/waddr/wdata inputs.

Parameters:
WIDTH, 32, data word width
DEPTH, 32, RAM entries; ADDR_WIDTH = $clog2(DEPTH)
N_REQ, 4, number of requesters (>= 1)
N_WRITE, 2, RAM write ports (1 <= N_WRITE <= N_REQ)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
req_valid  in  N_REQ  requester i has a write pending
req_addr  in  N_REQ x ADDR_WIDTH  write address per requester
req_data  in  N_REQ x WIDTH  write data per requester
req_ready  out  N_REQ  requester i granted this cycle
clear_req  in  1  pulse: re-zero whole RAM
init_done  out  1  high while in RUN
wen  out  N_WRITE  RAM write enables
waddr  out  N_WRITE x ADDR_WIDTH  RAM write addresses
wdata  out  N_WRITE x WIDTH  RAM write data

Behaviour:
- Reset values:
  - state=INIT, sweep ptr=0, rr=0, init_done=0.
  - req_ready=0; wen=0, waddr=0, wdata=0 (outputs combinational from state, so these hold during reset).
- FSM states: INIT, RUN.
- INIT behaviour:
  - Port j drives wen[j] = (ptr+j < DEPTH), waddr[j] = ptr+j, wdata[j] = 0.
  - ptr += N_WRITE each cycle.
  - When ptr+N_WRITE >= DEPTH, go to RUN next cycle.
  - Sweep takes ceil(DEPTH/N_WRITE) cycles; 16 cycles at defaults.
  - req_ready=0 throughout; clear_req ignored.
- RUN behaviour:
  - init_done=1.
  - clear_req=1 -> INIT next cycle with ptr=0. That cycle's grants still proceed.
- Selection (RUN, combinational, same cycle):
  - Scan requesters in order rr, rr+1, ... mod N_REQ.
  - Requester k is granted if req_valid[k]=1, fewer than N_WRITE already granted, and req_addr[k] differs from every already-granted address.
  - The n-th grant drives port n; unused ports have wen=0.
  - req_ready[k] = grant[k].
- Handshake:
  - A transfer occurs when req_valid & req_ready.
  - req_ready may depend combinationally on req_valid/req_addr; requesters must not make req_valid depend on req_ready.
  - Requesters hold valid, addr and data until granted.
- Round-robin pointer:
  - If any grant, rr <= (index of last granted requester + 1) mod N_REQ.
  - Otherwise rr unchanged.
  - Guarantees starvation freedom.
- Address conflict: a losing requester stalls (ready=0) and wins a later cycle. rr advances past the winner, so the loser is scanned earlier next cycle.
- Boundaries:
  - DEPTH not a multiple of N_WRITE: out-of-range ports are masked in the final sweep cycle.
  - DEPTH=1: sweep is one cycle.
  - N_WRITE=N_REQ with all addresses distinct: all requesters granted.
  - resetn asserted mid-sweep or mid-RUN: immediately returns to reset values and restarts the sweep.

Optional Feature:
LVTRAM_ARB_OUTREG_EN
- Defined:
  - wen/waddr/wdata are registered (reset to 0), so the RAM write lands one cycle after the grant.
  - init_done rises one cycle after the final sweep write is registered.
  - req_ready timing is unchanged.
  - Read-after-write visibility slips one cycle; consumers must tolerate it.
- Undefined: write ports are combinational from the grant/sweep logic; zero added latency.

Decomposition:
Package lvtram_arb_pkg:
- state_e enum {INIT, RUN}
- parameterised width helpers: ADDR_WIDTH, grant-index type
One sub-module, lvtram_arb_select:
- purely combinational rotate/scan/conflict-mask selection.
- Inputs: valid, addr, rr.
- Outputs: grant vector, per-port source index, per-port valid, last-granted index.
- The top level holds FSM, ptr, rr and output mux/registers.

Test Plan:
1. Sweep: DEPTH=32, N_WRITE=2, release resetn -> 16 cycles of wen=2'b11 with waddr pairs (0,1)..(30,31), wdata=0; init_done=1 on cycle 17; req_ready=0 throughout. Repeat with DEPTH=5, N_WRITE=2 -> 3 cycles, last cycle wen=2'b01, waddr[0]=4.
2. Full parallel: RUN, all 4 valid, addrs 1,2,3,4, rr=0 -> ready=0011, ports get addrs 1,2, rr=2. Next cycle -> ready=1100, ports get addrs 3,4, rr=0.
3. Conflict: req0 and req1 both addr 7, data 0xA/0xB, rr=0 -> only req0 granted, wen=2'b01, rr=1. Next cycle req1 granted with data 0xB; RAM word 7 ends as 0xB.
4. Fairness: req0..3 held valid forever at distinct addrs, N_WRITE=1 -> grants rotate 0,1,2,3,0, each requester once per 4 cycles.
5. clear_req in RUN with req2 valid -> req2 granted that cycle; next cycle INIT, init_done=0, sweep restarts at ptr=0. clear_req pulsed mid-sweep -> ignored, sweep length unchanged.
6. Async reset mid-sweep (cycle 5): wen drops to 0 immediately; after release, sweep restarts at waddr 0. With LVTRAM_ARB_OUTREG_EN: every wen/waddr is one cycle later than in scenarios 1–5.
